// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: majority-samples RX_IN around mid-bit using the
// external edge/bit counters, deserializes LSB-first and checks parity and stop.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [4:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                state_q;
  logic [4:0]            presc_q;
  logic                  par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q, pdata_q;
  logic                  s0_q, s1_q, s2_q;
  logic                  par_flag_q;
  logic                  cnt_en_q, dv_q, perr_q, serr_q;

  logic [4:0] half;
  logic       decide, bit_v, par_exp, in_frame;
  logic [3:0] stop_idx;

  assign half     = presc_q >> 1;
  assign decide   = (edge_cnt == half + 5'd2);
  assign bit_v    = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
  assign par_exp  = par_typ_q ? ~^shift_q : ^shift_q;
  assign stop_idx = 4'(DATA_WIDTH + 1) + {3'b000, par_en_q};
  assign in_frame = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_q    <= '0;
      pdata_q    <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      par_flag_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
      serr_q <= 1'b0;
      if (in_frame) begin
        if (edge_cnt == half - 5'd1) s0_q <= RX_IN;
        if (edge_cnt == half)        s1_q <= RX_IN;
        if (edge_cnt == half + 5'd1) s2_q <= RX_IN;
      end
      case (state_q)
        IDLE: if (!RX_IN) begin
          state_q   <= START;
          cnt_en_q  <= 1'b1;
          presc_q   <= Prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end
        START: if (decide && bit_cnt == 4'd0) begin
          if (bit_v) begin
            state_q  <= IDLE;
            cnt_en_q <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (decide && bit_cnt != 4'd0 && bit_cnt <= 4'(DATA_WIDTH)) begin
          shift_q <= {bit_v, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt == 4'(DATA_WIDTH)) state_q <= par_en_q ? PARITY : STOP;
        end
        PARITY: if (decide && bit_cnt == 4'(DATA_WIDTH + 1)) begin
          par_flag_q <= (bit_v != par_exp);
          state_q    <= STOP;
        end
        // Strobes are registered here so they are high exactly during DONE.
        STOP: if (decide && bit_cnt == stop_idx) begin
          state_q  <= DONE;
          cnt_en_q <= 1'b0;
          serr_q   <= ~bit_v;
          perr_q   <= par_flag_q;
          if (bit_v && !par_flag_q) begin
            dv_q    <= 1'b1;
            pdata_q <= shift_q;
          end
        end
        DONE: begin
          par_flag_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_enable = cnt_en_q;
  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: emulates the edge/bit counter, drives frames and
// checks every cycle against a frame-level timing/outcome model.
module tb_uart_rx_frame_ctrl;
  localparam int DW = 8;

  logic       CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1;
  logic [4:0] Prescale = 5'd8;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [4:0] edge_cnt = '0;
  logic [3:0] bit_cnt = '0;
  logic       cnt_enable, data_valid, par_err, stp_err;
  logic [DW-1:0] P_DATA;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .cnt_enable(cnt_enable), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err));

  always #5 CLK = ~CLK;

  int cyc = 0;
  int cnt_p = 8;
  logic rst_seen = 1'b0;
  bit run = 1'b0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) rst_seen <= ~RST;

  // edge_bit_counter stand-in
  always @(posedge CLK) begin
    if (!cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == 5'(cnt_p - 1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  typedef struct {
    int en_from; int en_to; int stb;
    bit dv; bit pe; bit se; logic [7:0] d;
  } exp_t;
  exp_t q[$];
  int ready = 0;
  int n_chk = 0, n_pass = 0, dv_cnt = 0;
  logic [7:0] exp_pdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  function automatic bit req_par(input bit pt, input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  always @(negedge CLK) begin : cmp
    bit en, dv, pe, se;
    if (run) begin
      if (rst_seen) begin
        exp_pdata = '0;
        chk("reset_outs", {cnt_enable, data_valid, par_err, stp_err, P_DATA}, 32'd0);
      end else begin
        en = 0; dv = 0; pe = 0; se = 0;
        foreach (q[i]) begin
          if (cyc >= q[i].en_from && cyc <= q[i].en_to) en = 1;
          if (cyc == q[i].stb) begin
            dv = q[i].dv; pe = q[i].pe; se = q[i].se;
            if (q[i].dv) exp_pdata = q[i].d;
          end
        end
        if (data_valid === 1'b1) dv_cnt++;
        chk("cnt_enable", cnt_enable, en);
        chk("strobes", {data_valid, par_err, stp_err}, {dv, pe, se});
        chk("P_DATA", P_DATA, exp_pdata);
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) tick();
  endtask

  // One frame; a frame only starts once the receiver is back in IDLE.
  task automatic send(input int p, input bit pe, input bit pt, input logic [7:0] d,
                      input bit par_bad, input bit stop_v, input bit ctr_inv, input bit scramble);
    int h, det, sb, nb;
    bit pbit, v, line;
    exp_t e;
    h = p / 2; sb = DW + 1 + pe; nb = DW + 2 + pe;
    Prescale = 5'(p); PAR_EN = pe; PAR_TYP = pt; cnt_p = p;
    det = (cyc > ready) ? cyc : ready;
    pbit = par_bad ? ~req_par(pt, d) : req_par(pt, d);
    e.en_from = det + 1; e.en_to = det + sb * p + h + 3; e.stb = det + sb * p + h + 4;
    e.pe = pe && par_bad; e.se = !stop_v; e.dv = !e.pe && !e.se; e.d = d;
    q.push_back(e);
    ready = e.stb + 1;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) v = 0;
      else if (b <= DW) v = d[b-1];
      else if (pe && b == DW + 1) v = pbit;
      else v = stop_v;
      for (int k = 0; k < p; k++) begin
        line = v;
        if (ctr_inv && b >= 1 && b <= DW && k == h + 1) line = ~v;
        if (b == nb - 1 && !stop_v && k > h + 3) line = 1;
        if (scramble && b == 0 && k == 2) begin
          Prescale = ($urandom_range(0, 1) == 1) ? 5'd16 : 5'd8;
          PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        end
        RX_IN = line;
        tick();
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic glitch(input int p);
    int det;
    exp_t e;
    Prescale = 5'(p); cnt_p = p;
    det = (cyc > ready) ? cyc : ready;
    e.en_from = det + 1; e.en_to = det + 1 + p / 2 + 2; e.stb = -1;
    e.dv = 0; e.pe = 0; e.se = 0; e.d = '0;
    q.push_back(e);
    ready = det + p / 2 + 4;
    RX_IN = 1'b0; tick(); tick();
    RX_IN = 1'b1;
  endtask

  initial begin
    int d0;
    RST = 1'b0;
    tick(); run = 1;
    tick(); tick();
    RST = 1'b1; ready = cyc;
    idle(5);

    chk("model_par_odd_3C", 32'(req_par(1, 8'h3C)), 32'd1);
    chk("model_par_even_A5", 32'(req_par(0, 8'hA5)), 32'd0);

    // Reset in the middle of a frame: start + three data bits, then RST low 3 CLK
    begin
      exp_t e;
      int det;
      Prescale = 5'd8; PAR_EN = 0; PAR_TYP = 0; cnt_p = 8;
      det = (cyc > ready) ? cyc : ready;
      e.en_from = det + 1; e.en_to = 1 << 30; e.stb = -1;
      e.dv = 0; e.pe = 0; e.se = 0; e.d = '0;
      q.push_back(e);
      RX_IN = 0; repeat (8) tick();
      RX_IN = 1; repeat (8) tick();
      RX_IN = 0; repeat (8) tick();
      RX_IN = 1; repeat (8) tick();
      RST = 1'b0; tick();
      q.delete();
      tick(); tick();
      RST = 1'b1; ready = cyc;
      RX_IN = 1'b1;
    end
    idle(4);
    send(8, 0, 0, 8'h11, 0, 1, 0, 0); idle(4);
    chk("lit_after_reset_11", P_DATA, 8'h11);

    send(8, 1, 0, 8'hA5, 0, 1, 0, 0); idle(4);
    chk("lit_good_A5", P_DATA, 8'hA5);
    send(8, 1, 1, 8'h3C, 1, 1, 0, 0); idle(4);
    chk("lit_par_err_hold", P_DATA, 8'hA5);
    send(16, 0, 0, 8'h81, 0, 0, 0, 0); idle(12);
    chk("lit_stp_err_hold", P_DATA, 8'hA5);

    glitch(8); idle(12);
    send(8, 0, 0, 8'h66, 0, 1, 0, 0); idle(4);
    chk("lit_after_glitch", P_DATA, 8'h66);

    d0 = dv_cnt;
    send(8, 1, 0, 8'h5A, 0, 1, 1, 0);
    send(8, 1, 0, 8'hC3, 0, 1, 0, 0); idle(4);
    chk("lit_b2b_C3", P_DATA, 8'hC3);
    chk("lit_b2b_dv_pulses", dv_cnt - d0, 32'd2);

    for (int i = 0; i < 40; i++) begin
      send(($urandom_range(0, 1) == 1) ? 16 : 8, 1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, 0, 1);
      idle($urandom_range(0, 3));
    end
    idle(30);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
